// File: rtl/defines.sv
// Shared pipeline definitions: datapath width, forwarding selects and
// fetch-stage types used by the front end and decode.
package defines;

  localparam int DEF_XLEN = 64;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries {pc, instr} with single-cycle flush.
// Power-of-two depth; pointers wrap naturally.
module fetch_fifo
  import defines::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // NOTE: storage is deliberately not reset; validity lives only in count,
  // so clearing the array would add reset fanout without changing behaviour.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction fetch: PC, credit-limited in-order imem requests,
// response buffering, redirect/drop handling and the IF/ID register.
module fetch_stage
  import defines::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_fetch,
  input  logic            stall_decode,
  input  logic            taken_branch,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            valid_decode,
  output logic [31:0]     instr_decode,
  output logic [XLEN-1:0] pc_decode
);

  localparam int           CW      = $clog2(BUF_DEPTH + 1);
  localparam int           AW      = $clog2(BUF_DEPTH);
  localparam logic [CW:0]  DEPTH_C = (CW + 1)'(BUF_DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  // PC tags of live (non-dropped) requests, in issue order.
  logic [XLEN-1:0] tag_mem [BUF_DEPTH];
  logic [AW-1:0]   tag_wr;
  logic [AW-1:0]   tag_rd;

  fetch_entry_t    fifo_in;
  fetch_entry_t    fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_pop;

  logic [CW:0]     in_use;
  logic            req_fire;
  logic            rsp_keep;

  always_comb begin
    in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req_valid = !stall_fetch && !taken_branch && !fifo_full && (in_use < DEPTH_C);
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && !taken_branch && (drop_cnt == '0);
    fifo_pop       = !taken_branch && !stall_decode && !fifo_empty;
    fifo_in.pc     = tag_mem[tag_rd];
    fifo_in.instr  = imem_rsp_data;
  end

  assign imem_req_addr = pc;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .flush     (taken_branch),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr] <= pc;
    end
  end

  // A redirect turns every request still in flight into a word to discard,
  // except a response landing in the redirect cycle, which is dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else if (taken_branch) begin
      pc          <= branch_target;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (req_fire) begin
        pc     <= pc + XLEN'(4);
        tag_wr <= tag_wr + 1'b1;
      end
      if (rsp_keep) begin
        tag_rd <= tag_rd + 1'b1;
      end
      if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      unique case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_decode <= 1'b0;
      instr_decode <= NOP_INSTR;
      pc_decode    <= '0;
    end else if (taken_branch) begin
      valid_decode <= 1'b0;
      instr_decode <= NOP_INSTR;
    end else if (!stall_decode) begin
      if (!fifo_empty) begin
        valid_decode <= 1'b1;
        instr_decode <= fifo_head.instr;
        pc_decode    <= fifo_head.pc;
      end else begin
        valid_decode <= 1'b0;
        instr_decode <= NOP_INSTR;
      end
    end
  end

endmodule
